// File: rtl/varint_stream_encoder.sv
// Word-to-byte stream encoder: LEB128-style varint (optionally zigzag with VARINT_ZIGZAG_EN) or raw strobed lanes.
// One word in flight; first byte one cycle after acceptance, then one byte per out_ready cycle.
module varint_stream_encoder #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic                clock_clk,
  input  logic                reset_reset_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_strb,
  input  logic                in_mode,
  input  logic [IDX_W-1:0]    in_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_last,
  output logic [15:0]         byte_cnt
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NB-1:0]     strb_q, strb_d;
  logic              mode_q, mode_d;
  logic [7:0]        obyte_q, obyte_d;
  logic [IDX_W-1:0]  oidx_q, oidx_d;
  logic              olast_q, olast_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [DATA_W-1:0] vin;
`ifdef VARINT_ZIGZAG_EN
  assign vin = {in_data[DATA_W-2:0], 1'b0} ^ {DATA_W{in_data[DATA_W-1]}};
`else
  assign vin = in_data;
`endif

  // One generator serves both the first byte (from the input word) and
  // every following byte (from the residual word held in data_q/strb_q).
  logic [DATA_W-1:0] src_data, gen_data;
  logic [NB-1:0]     src_strb, gen_strb;
  logic              src_mode;
  logic [7:0]        gen_byte;
  logic              gen_last;
  logic              raw_found;

  always_comb begin
    if (state_q == IDLE) begin
      src_data = in_mode ? in_data : vin;
      src_strb = in_strb;
      src_mode = in_mode;
    end else begin
      src_data = data_q;
      src_strb = strb_q;
      src_mode = mode_q;
    end
    gen_data  = src_data;
    gen_strb  = src_strb;
    gen_byte  = 8'h00;
    gen_last  = 1'b1;
    raw_found = 1'b0;
    if (src_mode) begin
      for (int i = 0; i < NB; i++) begin
        if (!raw_found && src_strb[i]) begin
          raw_found   = 1'b1;
          gen_byte    = src_data[i*8 +: 8];
          gen_strb[i] = 1'b0;
        end
      end
      gen_last = ~|gen_strb;
    end else begin
      gen_data = src_data >> 7;
      gen_byte = {|gen_data, src_data[6:0]};
      gen_last = ~|gen_data;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    strb_d  = strb_q;
    mode_d  = mode_q;
    obyte_d = obyte_q;
    oidx_d  = oidx_q;
    olast_d = olast_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d  = gen_data;
            strb_d  = gen_strb;
            mode_d  = in_mode;
            obyte_d = gen_byte;
            oidx_d  = in_index;
            olast_d = gen_last;
            // A raw word with no enabled lane is swallowed without output.
            if (!in_mode || (|in_strb)) state_d = EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            cnt_d = cnt_q + 16'd1;
            if (olast_q) begin
              state_d = IDLE;
            end else begin
              data_d  = gen_data;
              strb_d  = gen_strb;
              obyte_d = gen_byte;
              olast_d = gen_last;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      strb_q  <= '0;
      mode_q  <= 1'b0;
      obyte_q <= 8'h00;
      oidx_q  <= '0;
      olast_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      mode_q  <= mode_d;
      obyte_q <= obyte_d;
      oidx_q  <= oidx_d;
      olast_q <= olast_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_data  = obyte_q;
  assign out_index = oidx_q;
  assign out_last  = olast_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_varint_stream_encoder.sv
// Randomized + directed bench for varint_stream_encoder (32-bit instance plus a 64-bit instance).
module tb_varint_stream_encoder;

  logic        clk;
  logic        reset_n;
  logic        clr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_strb;
  logic        in_mode;
  logic [9:0]  in_index;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [9:0]  out_index;
  logic        out_last;
  logic [15:0] byte_cnt;

  logic        in_valid64, in_ready64;
  logic [63:0] in_data64;
  logic [7:0]  in_strb64;
  logic        in_mode64;
  logic [9:0]  in_index64;
  logic        out_valid64, out_ready64;
  logic [7:0]  out_data64;
  logic [9:0]  out_index64;
  logic        out_last64;
  logic [15:0] byte_cnt64;

  int vectors;
  int miscompares;
  int exp_cnt;
  logic [7:0] exp_q[$];

  varint_stream_encoder #(.DATA_W(32), .IDX_W(10)) dut (
    .clock_clk(clk), .reset_reset_n(reset_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_strb(in_strb),
    .in_mode(in_mode), .in_index(in_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .byte_cnt(byte_cnt)
  );

  varint_stream_encoder #(.DATA_W(64), .IDX_W(10)) dut64 (
    .clock_clk(clk), .reset_reset_n(reset_n), .clr(clr),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_data(in_data64), .in_strb(in_strb64),
    .in_mode(in_mode64), .in_index(in_index64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
    .out_index(out_index64), .out_last(out_last64), .byte_cnt(byte_cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: expected byte stream for one word, from the encoding rules.
  task automatic build_exp(input logic [63:0] d, input logic [7:0] s, input logic m, input int w);
    logic [63:0] v;
    logic [63:0] b;
    longint      sx;
    exp_q.delete();
    if (m) begin
      for (int i = 0; i < w / 8; i++)
        if (s[i]) exp_q.push_back(d[i*8 +: 8]);
    end else begin
      v = (w == 32) ? (d & 64'h0000_0000_FFFF_FFFF) : d;
`ifdef VARINT_ZIGZAG_EN
      sx = (w == 32) ? longint'($signed(d[31:0])) : longint'(d);
      v  = 64'(sx * 2) ^ ((sx < 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
      if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
`else
      sx = 0;
`endif
      do begin
        b = v % 128;
        v = v / 128;
        exp_q.push_back({(v != 0), b[6:0]});
      end while (v != 0);
    end
  endtask

  task automatic run_word(input logic [31:0] d, input logic [3:0] s, input logic m,
                          input logic [9:0] idx, input int stall_first, input int stall_pct);
    int cycles;
    logic take;
    build_exp({32'h0, d}, {4'h0, s}, m, 32);
    check("idle_rdy", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_strb = s; in_mode = m; in_index = idx;
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check("empty_vld", out_valid, 0);
      check("empty_rdy", in_ready, 1);
      return;
    end
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 100) begin
      check("out_vld", out_valid, 1);
      check("out_dat", out_data, exp_q[0]);
      check("out_last", out_last, (exp_q.size() == 1));
      check("out_idx", out_index, idx);
      if (cycles < stall_first) take = 1'b0;
      else take = ($urandom_range(0, 99) >= stall_pct);
      out_ready = take;
      @(negedge clk);
      cycles++;
      if (take) begin
        void'(exp_q.pop_front());
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      end
      check("byte_cnt", byte_cnt, exp_cnt);
    end
    out_ready = 1'b0;
    check("done_vld", out_valid, 0);
    check("done_rdy", in_ready, 1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_cnt = 0;
    reset_n = 1'b0; clr = 1'b0;
    in_valid = 1'b0; in_data = '0; in_strb = '0; in_mode = 1'b0; in_index = '0; out_ready = 1'b0;
    in_valid64 = 1'b0; in_data64 = '0; in_strb64 = '0; in_mode64 = 1'b0; in_index64 = '0; out_ready64 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vld", out_valid, 0);
    check("rst_dat", out_data, 0);
    check("rst_idx", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_cnt", byte_cnt, 0);
    check("rst_vld64", out_valid64, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", in_ready, 1);
    check("rel_rdy64", in_ready64, 1);

    // 64-bit all-ones word
    build_exp(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 64);
    in_valid64 = 1'b1; in_data64 = 64'hFFFF_FFFF_FFFF_FFFF; in_index64 = 10'd77; out_ready64 = 1'b1;
    @(negedge clk);
    in_valid64 = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      check("v64_vld", out_valid64, 1);
      check("v64_dat", out_data64, exp_q[0]);
      check("v64_last", out_last64, (exp_q.size() == 1));
      check("v64_idx", out_index64, 77);
      void'(exp_q.pop_front());
      @(negedge clk);
    end
`ifdef VARINT_ZIGZAG_EN
    check("v64_cnt", byte_cnt64, 1);
`else
    check("v64_cnt", byte_cnt64, 10);
`endif
    check("v64_rdy", in_ready64, 1);
    out_ready64 = 1'b0;

    // directed words
    run_word(32'd300, 4'h0, 1'b0, 10'd5, 0, 0);
    run_word(32'hFFFF_FFFF, 4'h0, 1'b0, 10'd9, 0, 0);
    run_word(32'd0, 4'h0, 1'b0, 10'd1, 0, 0);
    run_word(32'd127, 4'h0, 1'b0, 10'd2, 0, 0);
    run_word(32'd128, 4'h0, 1'b0, 10'd3, 0, 0);
    run_word(32'h4433_2211, 4'b0101, 1'b1, 10'd4, 0, 0);
    run_word(32'h4433_2211, 4'b0000, 1'b1, 10'd6, 0, 0);
    run_word(32'h4433_2211, 4'b1111, 1'b1, 10'd7, 0, 0);
    run_word(32'd300, 4'h0, 1'b0, 10'd5, 3, 0);
    run_word(32'hFFFF_FFFF, 4'h0, 1'b0, 10'd11, 0, 0);
    run_word(32'd1, 4'h0, 1'b0, 10'd12, 0, 0);
    run_word(32'hFFFF_FFC0, 4'h0, 1'b0, 10'd13, 0, 0);

    // randomized words with random backpressure
    for (int n = 0; n < 60; n++)
      run_word($urandom >> $urandom_range(0, 31), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 0, 30);

    // clr wins over a simultaneous acceptance
    clr = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_data = 32'd300;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check("clr_acc_vld", out_valid, 0);
    check("clr_acc_rdy", in_ready, 1);
    check("clr_acc_cnt", byte_cnt, exp_cnt);

    // clr mid-word after two transfers
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_mode = 1'b0; in_index = 10'd21;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    exp_cnt = (exp_cnt + 2) & 16'hFFFF;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; out_ready = 1'b0;
    check("clr_vld", out_valid, 0);
    check("clr_rdy", in_ready, 1);
    check("clr_cnt", byte_cnt, exp_cnt);

    // reset mid-word after two transfers
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_mode = 1'b0; in_index = 10'd22;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_vld", out_valid, 0);
    check("mrst_dat", out_data, 0);
    check("mrst_idx", out_index, 0);
    check("mrst_last", out_last, 0);
    check("mrst_cnt", byte_cnt, 0);
    exp_cnt = 0;
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_rdy", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("mrst_quiet", out_valid, 0);
    end
    out_ready = 1'b0;
    run_word(32'd300, 4'h0, 1'b0, 10'd5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/varint_stream_encoder.md
VARINT_STREAM_ENCODER -- requirements
Module: varint_stream_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, input word width; legal values 32 and 64.
REQ-002 SHALL have parameter IDX_W, default 10, width of the per-word index tag.
REQ-003 SHALL have port clock_clk  input  1  the single clock.
REQ-004 SHALL have port reset_reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous abort/flush, active-high.
REQ-006 SHALL have port in_valid  input  1  input word valid.
REQ-007 SHALL have port in_ready  output  1  input word accepted when high with in_valid.
REQ-008 SHALL have port in_data  input  DATA_W  value or raw bytes.
REQ-009 SHALL have port in_strb  input  DATA_W/8  raw-mode byte enables.
REQ-010 SHALL have port in_mode  input  1  0 = varint encode, 1 = raw passthrough.
REQ-011 SHALL have port in_index  input  IDX_W  tag carried to every output byte.
REQ-012 SHALL have port out_valid  output  1  output byte valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts byte.
REQ-014 SHALL have port out_data  output  8  encoded or raw byte.
REQ-015 SHALL have port out_index  output  IDX_W  tag of the source word.
REQ-016 SHALL have port out_last  output  1  final byte of the source word.
REQ-017 SHALL have port byte_cnt  output  16  count of completed output transfers.

Function
REQ-018 SHALL implement FSM IDLE/EMIT:
- in_ready = 1 only in IDLE.
- Accepting a word registers data, strb, mode and index, then moves to EMIT.
REQ-019 SHALL present the first output byte in the cycle after acceptance: out_valid high, one-cycle latency.
REQ-020 SHALL, in varint mode, emit 7-bit groups LSB first:
- bit7 = 1 when further nonzero groups remain; bit7 = 0 on the final byte, with out_last = 1.
- Value 0 emits a single byte 0x00.
- Maximum emitted bytes: 5 for DATA_W=32, 10 for DATA_W=64.
REQ-021 SHALL, in raw mode, emit only lanes with a strb bit set, in ascending lane order. out_last = 1 on the highest enabled lane.
REQ-022 SHALL, in raw mode with strb all zero, consume the word, emit no byte and remain in IDLE.
REQ-023 SHALL hold out_data, out_index and out_last stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL advance to the next byte only on out_valid && out_ready. On the out_last transfer it returns to IDLE, with in_ready high the following cycle.
REQ-025 SHALL increment byte_cnt by 1 per out_valid && out_ready transfer. byte_cnt wraps from 0xFFFF to 0x0000 and is not cleared by clr.
REQ-026 SHALL, on clr, drop any word in progress, force IDLE and deassert out_valid next cycle. clr has priority over a simultaneous acceptance or transfer, and neither is counted.

Reset
REQ-027 SHALL, when reset_reset_n = 0 at a clock edge, set state to IDLE and clear out_valid, out_data, out_index, out_last and byte_cnt to 0. in_ready = 1 in the first cycle after release.
REQ-028 SHALL apply reset mid-word with the same effect; no byte of the interrupted word appears after release.

Configuration
REQ-029 SHALL, with macro VARINT_ZIGZAG_EN defined, zigzag-transform varint-mode input before encoding: z = (x << 1) ^ (x >>> (DATA_W-1)), x signed.
REQ-030 SHALL, without VARINT_ZIGZAG_EN, encode varint input as unsigned. Raw mode is identical in both builds.

Verification
REQ-031 SHALL cover: varint, in_data=300, index=5 -> 0xAC, 0x02, out_last on 2nd byte, out_index=5 on both, byte_cnt +2.
REQ-032 SHALL cover: DATA_W=32 varint 0xFFFFFFFF -> 0xFF,0xFF,0xFF,0xFF,0x0F. DATA_W=64, 0xFFFFFFFFFFFFFFFF -> nine 0xFF then 0x01.
REQ-033 SHALL cover: raw, data=0x44332211, strb=0101 -> 0x11 then 0x33 (last). strb=0000 -> no output, in_ready high next cycle.
REQ-034 SHALL cover: varint 300 with out_ready low for 3 cycles after first out_valid -> 0xAC held stable, then 0xAC, 0x02 delivered without loss.
REQ-035 SHALL cover: VARINT_ZIGZAG_EN build, in_data=-1 -> 0x01; in_data=1 -> 0x02; in_data=-64 -> 0x7F.
REQ-036 SHALL cover: varint 0xFFFFFFFF with reset_reset_n low after 2nd byte -> all outputs 0, in_ready=1 after release. The same case with clr instead -> byte_cnt retains 2.
